interrupt_controller: RTL and testbench

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 101 ++++++++++
 tb/tb_interrupt_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// Four-source interrupt controller: rising-edge pending capture, mask, fixed
// lowest-index priority, and a one-shot ISR entry request held until RETI.
module interrupt_controller #(
  parameter logic [5:0]  RETI_OP  = 6'b011110,
  parameter logic [15:0] ISR_BASE = 16'hF000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        mask_we,
  input  logic [3:0]  mask_data,
  input  logic        int_en,
  input  logic [5:0]  op,
  input  logic        pc_mux_sel,
  output logic        interrupt,
  output logic [1:0]  irq_id,
  output logic [15:0] isr_addr,
  output logic        in_service,
  output logic [3:0]  pending,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  irq_q;
  logic [3:0]  pending_q, pending_d;
  logic [3:0]  mask_q, mask_d;
  logic [1:0]  irq_id_q, irq_id_d;
  logic [3:0]  rise;
  logic [3:0]  eligible;
  logic [3:0]  clr;
  logic [1:0]  win_id;

  assign rise     = irq_in & ~irq_q;
  assign eligible = pending_q & mask_q;
  assign mask_d   = mask_we ? mask_data : mask_q;

  always_comb begin
    win_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) win_id = 2'(i);
    end
  end

  // interrupt is a fire-and-forget strobe: the jump control block has no
  // ready/ack; it must act in the single cycle interrupt is high.
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    clr      = 4'b0000;
    unique case (state_q)
      IDLE: begin
        if (int_en && (|eligible) && !pc_mux_sel) begin
          state_d  = ISSUE;
          irq_id_d = win_id;
        end
      end
      ISSUE: begin
        clr[irq_id_q] = 1'b1;
        state_d       = SERVICE;
      end
      SERVICE: begin
        if (op == RETI_OP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A coinciding new edge on the cleared source wins over the clear.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      irq_q     <= 4'b0000;
      pending_q <= 4'b0000;
      mask_q    <= 4'b0000;
      irq_id_q  <= 2'd0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      irq_id_q  <= irq_id_d;
    end
  end

  // Gated by reset so an abandoned ISSUE cycle never leaks a pulse.
  assign interrupt  = (state_q == ISSUE) && !reset;
  assign in_service = (state_q != IDLE);
  assign irq_id     = irq_id_q;
  assign isr_addr   = ISR_BASE + {12'b0, irq_id_q, 2'b00};
  assign pending    = pending_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and random stimulus for interrupt_controller, checked against a
// cycle-level behavioural model of the interrupt rules.
module tb_interrupt_controller;

  localparam logic [5:0] RETI = 6'b011110;

  logic        clk;
  logic        reset;
  logic [3:0]  irq_in;
  logic        mask_we;
  logic [3:0]  mask_data;
  logic        int_en;
  logic [5:0]  op;
  logic        pc_mux_sel;
  logic        interrupt;
  logic [1:0]  irq_id;
  logic [15:0] isr_addr;
  logic        in_service;
  logic [3:0]  pending;
  logic [1:0]  state_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: per-source pending flags, previous line levels, mask, and the
  // service phase (0 = free, 1 = entry pulse this cycle, 2 = running ISR).
  bit        m_prev [4];
  bit        m_pend [4];
  bit        m_mask [4];
  int        m_phase;
  int        m_id;
  logic      prev_int;

  interrupt_controller dut (
    .clk        (clk),
    .reset      (reset),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_data  (mask_data),
    .int_en     (int_en),
    .op         (op),
    .pc_mux_sel (pc_mux_sel),
    .interrupt  (interrupt),
    .irq_id     (irq_id),
    .isr_addr   (isr_addr),
    .in_service (in_service),
    .pending    (pending),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model_pending();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_edge();
    bit old_pend [4];
    int winner;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
      end
      m_phase = 0;
      m_id    = 0;
      return;
    end
    for (int i = 0; i < 4; i++) old_pend[i] = m_pend[i];
    winner = -1;
    for (int i = 0; i < 4; i++)
      if (winner < 0 && old_pend[i] && m_mask[i]) winner = i;
    if (m_phase == 1) m_pend[m_id] = 0;
    for (int i = 0; i < 4; i++)
      if (irq_in[i] && !m_prev[i]) m_pend[i] = 1;
    if (m_phase == 1) m_phase = 2;
    else if (m_phase == 2) begin
      if (op == RETI) m_phase = 0;
    end else if (int_en && !pc_mux_sel && winner >= 0) begin
      m_phase = 1;
      m_id    = winner;
    end
    for (int i = 0; i < 4; i++) begin
      if (mask_we) m_mask[i] = mask_data[i];
      m_prev[i] = irq_in[i];
    end
  endtask

  task automatic compare_all();
    logic exp_int;
    exp_int = (m_phase == 1) && !reset;
    check("interrupt", 32'(interrupt), 32'(exp_int));
    check("in_service", 32'(in_service), 32'(m_phase != 0));
    check("irq_id", 32'(irq_id), 32'(m_id));
    check("isr_addr", 32'(isr_addr), 32'h0000F000 + 32'(m_id * 4));
    check("pending", 32'(pending), 32'(model_pending()));
    check("no_back_to_back", 32'(prev_int & interrupt), 32'd0);
    prev_int = interrupt;
  endtask

  task automatic step(input logic [3:0] irq, input logic mwe, input logic [3:0] md,
                      input logic ie, input logic [5:0] o, input logic pcs,
                      input logic rst);
    irq_in = irq; mask_we = mwe; mask_data = md; int_en = ie;
    op = o; pc_mux_sel = pcs; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    prev_int = 1'b0;
    m_phase = 0; m_id = 0;
    for (int i = 0; i < 4; i++) begin
      m_prev[i] = 0; m_pend[i] = 0; m_mask[i] = 0;
    end
    irq_in = '0; mask_we = 0; mask_data = '0; int_en = 0; op = '0;
    pc_mux_sel = 0; reset = 1;
    #2;

    // reset state
    step(4'h0, 0, 4'h0, 0, 6'd0, 0, 1);
    step(4'h0, 0, 4'h0, 0, 6'd0, 0, 1);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_in_service", 32'(in_service), 32'd0);

    // single source 2, full mask
    step(4'h0, 1, 4'hF, 1, 6'd0, 0, 0);
    step(4'h4, 0, 4'h0, 1, 6'd0, 0, 0);
    check("src2_pending", 32'(pending), 32'h4);
    step(4'h4, 0, 4'h0, 1, 6'd0, 0, 0);
    check("src2_pulse", 32'(interrupt), 32'd1);
    check("src2_addr", 32'(isr_addr), 32'hF008);
    step(4'h4, 0, 4'h0, 1, 6'd0, 0, 0);
    check("src2_cleared", 32'(pending), 32'd0);
    step(4'h4, 0, 4'h0, 1, RETI, 0, 0);

    // sources 1 and 3 together: 1 first, then 3
    step(4'hA, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'hA, 0, 4'h0, 1, 6'd0, 0, 0);
    check("pri_id1", 32'(irq_id), 32'd1);
    step(4'hA, 0, 4'h0, 1, 6'd0, 0, 0);
    check("pri_left3", 32'(pending), 32'h8);
    step(4'hA, 0, 4'h0, 1, RETI, 0, 0);
    step(4'hA, 0, 4'h0, 1, 6'd0, 0, 0);
    check("pri_addr3", 32'(isr_addr), 32'hF00C);
    step(4'hA, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h0, 0, 4'h0, 1, RETI, 0, 0);

    // masked source held, then unmasked
    step(4'h0, 1, 4'h0, 1, 6'd0, 0, 0);
    step(4'h1, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h1, 0, 4'h0, 1, 6'd0, 0, 0);
    check("masked_kept", 32'(pending), 32'h1);
    step(4'h1, 1, 4'h1, 1, 6'd0, 0, 0);
    step(4'h1, 0, 4'h0, 1, 6'd0, 0, 0);
    check("unmask_pulse", 32'(interrupt), 32'd1);
    step(4'h0, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h0, 0, 4'h0, 1, RETI, 0, 0);

    // deferral under pc_mux_sel
    step(4'h0, 1, 4'hF, 1, 6'd0, 0, 0);
    step(4'h2, 0, 4'h0, 1, 6'd0, 1, 0);
    for (int k = 0; k < 3; k++) step(4'h2, 0, 4'h0, 1, 6'd0, 1, 0);
    step(4'h2, 0, 4'h0, 1, 6'd0, 0, 0);
    check("defer_pulse", 32'(interrupt), 32'd1);

    // edge during service, then reset during service
    step(4'h2, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h3, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h3, 0, 4'h0, 1, 6'd0, 0, 0);
    check("nest_pending", 32'(pending), 32'h1);
    step(4'h3, 0, 4'h0, 1, RETI, 0, 0);
    step(4'h3, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h3, 0, 4'h0, 1, 6'd0, 0, 0);
    step(4'h7, 0, 4'h0, 1, 6'd0, 0, 1);
    check("rst_in_service", 32'(in_service), 32'd0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [3:0] irq_r;
      logic [5:0] op_r;
      irq_r = irq_in;
      for (int b = 0; b < 4; b++)
        if ($urandom_range(0, 99) < 15) irq_r[b] = ~irq_r[b];
      op_r = ($urandom_range(0, 99) < 30) ? RETI : 6'($urandom_range(0, 63));
      step(irq_r, $urandom_range(0, 99) < 10, 4'($urandom_range(0, 15)),
           $urandom_range(0, 99) < 80, op_r, $urandom_range(0, 99) < 25,
           $urandom_range(0, 99) < 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
